// File: rtl/month_ctrl_pkg.sv
// Month counter types and helpers: step kinds, month legality, leap decode
// and the month-length table.
package month_ctrl_pkg;

  `include "calendar_defs.vh"

  typedef enum logic [1:0] {
    STEP_HOLD,
    STEP_ADV,
    STEP_RET,
    STEP_FIX
  } step_e;

  function automatic logic month_legal(input logic [4:0] m);
    if (m[4]) return (m[3:0] <= 4'd2);
    return (m[3:0] != 4'd0) && (m[3:0] <= 4'd9);
  endfunction

  // Years are 2000..2099, so leap is simply YY mod 4 == 0; in BCD that
  // depends on the parity of the tens digit.
  function automatic logic year_is_leap(input logic [3:0] tens, input logic [3:0] ones);
    if ((tens > 4'd9) || (ones > 4'd9)) return 1'b0;
    if (!tens[0]) return (ones == 4'd0) || (ones == 4'd4) || (ones == 4'd8);
    return (ones == 4'd2) || (ones == 4'd6);
  endfunction

  function automatic logic [5:0] days_in_month(input logic [4:0] m, input logic leap);
    logic [5:0] d;
    d = D31;
    case (m)
      JAN, MAR, MAY, JUL, AUG, OCT, DEC: d = D31;
      APR, JUN, SEP, NOV:                d = D30;
      FEB:                               d = leap ? D29 : D28;
      default:                           d = D31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calendar_defs.vh
// Calendar constants shared by the day, month and year counters.
// Months are BCD {tens,ones}; day limits are BCD {tens[1:0],ones[3:0]}.
localparam logic [4:0] JAN = 5'h01;
localparam logic [4:0] FEB = 5'h02;
localparam logic [4:0] MAR = 5'h03;
localparam logic [4:0] APR = 5'h04;
localparam logic [4:0] MAY = 5'h05;
localparam logic [4:0] JUN = 5'h06;
localparam logic [4:0] JUL = 5'h07;
localparam logic [4:0] AUG = 5'h08;
localparam logic [4:0] SEP = 5'h09;
localparam logic [4:0] OCT = 5'h10;
localparam logic [4:0] NOV = 5'h11;
localparam logic [4:0] DEC = 5'h12;

localparam logic [5:0] D28 = 6'h28;
localparam logic [5:0] D29 = 6'h29;
localparam logic [5:0] D30 = 6'h30;
localparam logic [5:0] D31 = 6'h31;

// File: rtl/month_lastday_lut.sv
// Combinational last-day-of-month lookup in BCD.
module month_lastday_lut
  import month_ctrl_pkg::*;
(
  input  logic       month_tens_i,
  input  logic [3:0] month_ones_i,
  input  logic       leap_i,
  output logic [1:0] lastday_tens_o,
  output logic [3:0] lastday_ones_o
);

  logic [5:0] lastday;

  always_comb begin
    lastday = days_in_month({month_tens_i, month_ones_i}, leap_i);
  end

  assign lastday_tens_o = lastday[5:4];
  assign lastday_ones_o = lastday[3:0];

endmodule

// File: rtl/month_ctrl.sv
// BCD month counter (01..12) with leap-aware last-day output, year carry
// and a one-shot day clamp request toward the day counter.
module month_ctrl
  import month_ctrl_pkg::*;
#(
  parameter int RESET_MONTH    = 1,
  parameter bit YEAR_EN_ON_SET = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       month_en_i,
  input  logic       incr_i,
  input  logic       dcr_i,
  input  logic [3:0] year_ones_i,
  input  logic [3:0] year_tens_i,
  input  logic [3:0] day_ones_i,
  input  logic [1:0] day_tens_i,
  output logic [3:0] month_ones_o,
  output logic       month_tens_o,
  output logic [3:0] lastday_ones_o,
  output logic [1:0] lastday_tens_o,
  output logic       year_en_o,
  output logic       day_clamp_o
);

  localparam logic [4:0] RST_MONTH   = {(RESET_MONTH >= 10), 4'(RESET_MONTH % 10)};
  localparam logic [5:0] RST_LASTDAY = days_in_month(RST_MONTH, 1'b0);

  logic [4:0] month_q, month_d;
  logic [5:0] lastday_q;
  logic [5:0] day_q;
  logic       over_q;
  logic       year_en_q, year_en_d;
  logic       day_clamp_q;
  logic [1:0] ld_tens_d;
  logic [3:0] ld_ones_d;
  logic       adv, ret, wrap, leap, over;
  step_e      step;

  assign adv  = month_en_i | incr_i;
  assign ret  = dcr_i & ~adv;
  assign leap = year_is_leap(year_tens_i, year_ones_i);

  always_comb begin
    step = STEP_HOLD;
    if (!month_legal(month_q)) step = STEP_FIX;
    else if (adv)              step = STEP_ADV;
    else if (ret)              step = STEP_RET;
  end

  // Step logic: the only BCD carries are 09<->10 and the 12<->01 wrap.
  always_comb begin
    month_d = month_q;
    wrap    = 1'b0;
    case (step)
      STEP_FIX: month_d = JAN;
      STEP_ADV: begin
        if (month_q == DEC) begin
          month_d = JAN;
          wrap    = 1'b1;
        end else if (month_q == SEP) begin
          month_d = OCT;
        end else begin
          month_d = month_q + 5'd1;
        end
      end
      STEP_RET: begin
        if (month_q == OCT)      month_d = SEP;
        else if (month_q == JAN) month_d = DEC;
        else                     month_d = month_q - 5'd1;
      end
      default: month_d = month_q;
    endcase
  end

  assign year_en_d = wrap & (month_en_i | (YEAR_EN_ON_SET & incr_i));

  month_lastday_lut u_lastday_lut (
    .month_tens_i   (month_d[4]),
    .month_ones_i   (month_d[3:0]),
    .leap_i         (leap),
    .lastday_tens_o (ld_tens_d),
    .lastday_ones_o (ld_ones_d)
  );

  always_comb begin
    over = 1'b0;
    if (day_q[5:4] > lastday_q[5:4])
      over = 1'b1;
    else if ((day_q[5:4] == lastday_q[5:4]) && (day_q[3:0] > lastday_q[3:0]))
      over = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      month_q     <= RST_MONTH;
      lastday_q   <= RST_LASTDAY;
      day_q       <= '0;
      over_q      <= 1'b0;
      year_en_q   <= 1'b0;
      day_clamp_q <= 1'b0;
    end else begin
      month_q     <= month_d;
      lastday_q   <= {ld_tens_d, ld_ones_d};
      day_q       <= {day_tens_i, day_ones_i};
      over_q      <= over;
      year_en_q   <= year_en_d;
      // Fires on the rising edge of the compare only; re-arms once it drops.
      day_clamp_q <= over & ~over_q;
    end
  end

  assign month_tens_o   = month_q[4];
  assign month_ones_o   = month_q[3:0];
  assign lastday_tens_o = lastday_q[5:4];
  assign lastday_ones_o = lastday_q[3:0];
  assign year_en_o      = year_en_q;
  assign day_clamp_o    = day_clamp_q;

endmodule

// File: tb/tb_month_ctrl.sv
// Self-checking bench for month_ctrl: directed vector table, hand-written
// clamp/reset sequences and a randomized run against an integer model.
module tb_month_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       month_en_i, incr_i, dcr_i;
  logic [3:0] year_ones_i, year_tens_i, day_ones_i;
  logic [1:0] day_tens_i;
  logic [3:0] month_ones_o, lastday_ones_o;
  logic       month_tens_o, year_en_o, day_clamp_o;
  logic [1:0] lastday_tens_o;

  month_ctrl dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .month_en_i     (month_en_i),
    .incr_i         (incr_i),
    .dcr_i          (dcr_i),
    .year_ones_i    (year_ones_i),
    .year_tens_i    (year_tens_i),
    .day_ones_i     (day_ones_i),
    .day_tens_i     (day_tens_i),
    .month_ones_o   (month_ones_o),
    .month_tens_o   (month_tens_o),
    .lastday_ones_o (lastday_ones_o),
    .lastday_tens_o (lastday_tens_o),
    .year_en_o      (year_en_o),
    .day_clamp_o    (day_clamp_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct {
    logic       men;
    logic       inc;
    logic       dcr;
    logic [7:0] yr;
    int         exp_m;
    int         exp_ld;
    logic       exp_ye;
  } vec_t;

  vec_t vecs[$];

  // Integer reference model state
  int m_month, m_last, m_dreg;
  bit m_ye, m_clamp, m_over;

  function automatic int dut_month();
    return int'(month_tens_o) * 10 + int'(month_ones_o);
  endfunction

  function automatic int dut_last();
    return int'(lastday_tens_o) * 10 + int'(lastday_ones_o);
  endfunction

  function automatic bit ref_leap(input logic [7:0] y);
    int t, o;
    t = int'(y[7:4]);
    o = int'(y[3:0]);
    if (t > 9 || o > 9) return 1'b0;
    return ((t * 10 + o) % 4) == 0;
  endfunction

  function automatic int ref_days(input int m, input bit leap);
    int tbl[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    if (m == 2 && leap) return 29;
    return tbl[m - 1];
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_year(input logic [7:0] y);
    year_tens_i = y[7:4];
    year_ones_i = y[3:0];
  endtask

  task automatic set_day(input int d);
    day_tens_i = 2'(d / 10);
    day_ones_i = 4'(d % 10);
  endtask

  task automatic set_strobes(input logic men, input logic inc, input logic dcr);
    month_en_i = men;
    incr_i     = inc;
    dcr_i      = dcr;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    set_strobes(0, 0, 0);
    repeat (2) tick();
    check({tag, "_rst_month"}, dut_month(), 1);
    check({tag, "_rst_lastday"}, dut_last(), 31);
    check({tag, "_rst_year_en"}, int'(year_en_o), 0);
    check({tag, "_rst_clamp"}, int'(day_clamp_o), 0);
    rst_n = 1'b1;
    m_month = 1; m_last = 31; m_dreg = 0;
    m_ye = 0; m_clamp = 0; m_over = 0;
  endtask

  task automatic add(input logic men, input logic inc, input logic dcr, input logic [7:0] yr,
                     input int m, input int ld, input logic ye);
    vec_t v;
    v.men = men; v.inc = inc; v.dcr = dcr; v.yr = yr;
    v.exp_m = m; v.exp_ld = ld; v.exp_ye = ye;
    vecs.push_back(v);
  endtask

  task automatic model_tick(input logic men, input logic inc, input logic dcr,
                            input logic [7:0] yr, input int day);
    bit adv, ret, over;
    adv = men | inc;
    ret = dcr & ~adv;
    over = (m_dreg > m_last);
    m_clamp = over && !m_over;
    m_over  = over;
    m_ye    = adv && (m_month == 12) && men;
    if (adv)      m_month = (m_month % 12) + 1;
    else if (ret) m_month = (m_month == 1) ? 12 : m_month - 1;
    m_last = ref_days(m_month, ref_leap(yr));
    m_dreg = day;
  endtask

  initial begin
    rst_n = 1'b0;
    set_strobes(0, 0, 0);
    set_year(8'h23);
    set_day(1);

    // ---------------- directed table ----------------
    add(1,0,0,8'h23, 2,28,0);  add(1,0,0,8'h23, 3,31,0);  add(1,0,0,8'h23, 4,30,0);
    add(1,0,0,8'h23, 5,31,0);  add(1,0,0,8'h23, 6,30,0);  add(1,0,0,8'h23, 7,31,0);
    add(1,0,0,8'h23, 8,31,0);  add(1,0,0,8'h23, 9,30,0);  add(1,0,0,8'h23,10,31,0);
    add(1,0,0,8'h23,11,30,0);  add(1,0,0,8'h23,12,31,0);  add(1,0,0,8'h23, 1,31,1);
    add(0,0,0,8'h23, 1,31,0);
    add(0,1,0,8'h24, 2,29,0);  add(0,0,0,8'h23, 2,28,0);  add(0,0,0,8'h00, 2,29,0);
    add(0,0,0,8'hA0, 2,28,0);  add(0,0,0,8'h24, 2,29,0);
    add(0,0,1,8'h24, 1,31,0);  add(0,0,1,8'h24,12,31,0);  add(0,0,1,8'h24,11,30,0);
    add(0,0,1,8'h24,10,31,0);  add(0,0,1,8'h24, 9,30,0);  add(0,1,0,8'h24,10,31,0);
    add(0,0,1,8'h24, 9,30,0);  add(0,0,1,8'h24, 8,31,0);  add(0,0,1,8'h24, 7,31,0);
    add(0,0,1,8'h24, 6,30,0);  add(0,0,1,8'h24, 5,31,0);
    add(0,1,1,8'h24, 6,30,0);  add(0,0,1,8'h24, 5,31,0);  add(1,1,0,8'h24, 6,30,0);
    add(1,0,1,8'h24, 7,31,0);
    add(0,1,0,8'h24, 8,31,0);  add(0,1,0,8'h24, 9,30,0);  add(0,1,0,8'h24,10,31,0);
    add(0,1,0,8'h24,11,30,0);  add(0,1,0,8'h24,12,31,0);  add(0,1,0,8'h24, 1,31,0);

    do_reset("tbl");
    foreach (vecs[i]) begin
      set_strobes(vecs[i].men, vecs[i].inc, vecs[i].dcr);
      set_year(vecs[i].yr);
      tick();
      $display("vec %0d: en=%0b inc=%0b dcr=%0b yr=%h -> month %0d lastday %0d year_en %0b",
               i, vecs[i].men, vecs[i].inc, vecs[i].dcr, vecs[i].yr,
               dut_month(), dut_last(), year_en_o);
      check($sformatf("vec%0d_month", i), dut_month(), vecs[i].exp_m);
      check($sformatf("vec%0d_lastday", i), dut_last(), vecs[i].exp_ld);
      check($sformatf("vec%0d_year_en", i), int'(year_en_o), int'(vecs[i].exp_ye));
      check($sformatf("vec%0d_clamp", i), int'(day_clamp_o), 0);
    end
    set_strobes(0, 0, 0);

    // ---------------- month shrink under day 31 ----------------
    do_reset("shrink");
    set_year(8'h24);
    set_day(1);
    set_strobes(0, 1, 0); tick(); tick();
    set_strobes(0, 0, 0);
    set_day(31); tick(); tick();
    check("shrink_month03", dut_month(), 3);
    check("shrink_no_clamp_at_31", int'(day_clamp_o), 0);
    set_strobes(0, 0, 1); tick();
    set_strobes(0, 0, 0);
    $display("shrink: dcr -> month %0d lastday %0d clamp %0b", dut_month(), dut_last(), day_clamp_o);
    check("shrink_month02", dut_month(), 2);
    check("shrink_lastday29", dut_last(), 29);
    check("shrink_clamp_not_yet", int'(day_clamp_o), 0);
    tick();
    $display("shrink: next cycle clamp %0b", day_clamp_o);
    check("shrink_clamp_pulse", int'(day_clamp_o), 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("shrink_no_repulse%0d", k), int'(day_clamp_o), 0);
    end

    // ---------------- leap loss at 02/29 ----------------
    do_reset("leap");
    set_year(8'h24);
    set_day(1);
    set_strobes(0, 1, 0); tick();
    set_strobes(0, 0, 0);
    set_day(29); tick(); tick();
    check("leap_eq_no_clamp", int'(day_clamp_o), 0);
    check("leap_lastday29", dut_last(), 29);
    set_year(8'h25); tick();
    $display("leap: year 25 -> lastday %0d clamp %0b", dut_last(), day_clamp_o);
    check("leap_lastday28", dut_last(), 28);
    check("leap_clamp_not_yet", int'(day_clamp_o), 0);
    tick();
    check("leap_clamp_pulse", int'(day_clamp_o), 1);
    tick();
    check("leap_clamp_single", int'(day_clamp_o), 0);
    // Re-arm: day drops to legal, then the year grows leap again and loses it
    set_day(28); tick(); tick();
    check("rearm_idle", int'(day_clamp_o), 0);
    set_day(29); set_year(8'h24); tick(); tick(); tick();
    check("rearm_eq_no_clamp", int'(day_clamp_o), 0);
    set_year(8'h27); tick(); tick();
    check("rearm_clamp_pulse", int'(day_clamp_o), 1);

    // ---------------- async reset during year_en ----------------
    do_reset("yen");
    set_year(8'h24);
    set_day(1);
    set_strobes(0, 0, 1); tick();
    check("yen_month12", dut_month(), 12);
    check("yen_dcr_no_year_en", int'(year_en_o), 0);
    set_strobes(1, 0, 0); tick();
    set_strobes(0, 0, 0);
    check("yen_pulse", int'(year_en_o), 1);
    #2 rst_n = 1'b0;
    #1;
    $display("yen: async reset -> month %0d year_en %0b", dut_month(), year_en_o);
    check("yen_async_year_en", int'(year_en_o), 0);
    check("yen_async_month", dut_month(), 1);
    check("yen_async_lastday", dut_last(), 31);

    // ---------------- randomized run against model ----------------
    do_reset("rand");
    begin
      logic [7:0] yr;
      int         day;
      logic       men, inc, dcr;
      yr  = 8'h24;
      day = 1;
      for (int c = 0; c < 800; c++) begin
        if ($urandom_range(0, 15) == 0) begin
          if ($urandom_range(0, 9) == 0) yr = 8'($urandom);
          else yr = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
        end
        if ($urandom_range(0, 5) == 0) day = $urandom_range(1, 31);
        men = ($urandom_range(0, 2) == 0);
        inc = ($urandom_range(0, 5) == 0);
        dcr = ($urandom_range(0, 3) == 0);
        set_strobes(men, inc, dcr);
        set_year(yr);
        set_day(day);
        tick();
        model_tick(men, inc, dcr, yr, day);
        check($sformatf("rand%0d_month", c), dut_month(), m_month);
        check($sformatf("rand%0d_lastday", c), dut_last(), m_last);
        check($sformatf("rand%0d_year_en", c), int'(year_en_o), int'(m_ye));
        check($sformatf("rand%0d_clamp", c), int'(day_clamp_o), int'(m_clamp));
      end
      set_strobes(0, 0, 0);
      #3 rst_n = 1'b0;
      #1;
      check("rand_async_month", dut_month(), 1);
      check("rand_async_lastday", dut_last(), 31);
      check("rand_async_year_en", int'(year_en_o), 0);
      check("rand_async_clamp", int'(day_clamp_o), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
